tiger_round_ctrl: RTL

Executes one Tiger hash round step and acts as the reader of the four Tiger S-box ROMs (tiger_sbox_a/b/c/d). Each ROM is single-port and synchronous, so this block issues byte addresses to them and consumes their registered 64-bit data one cycle later.
- Round step: c' = c ^ x; a' = a - (T1[c'0]^T2[c'2]^T3[c'4]^T4[c'6]); b' = (b + (T4[c'1]^T3[c'3]^T2[c'5]^T1[c'7])) * mul, all mod 2^64.
- Byte k of c' is bits [8k+7:8k].
- Sits between the Tiger pass/schedule controller and the S-box instances.

---
 rtl/tiger_round_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/tiger_round_ctrl.sv
// One Tiger round step: c' = c ^ x, then two S-box lookup phases.
// Even-byte and odd-byte table reads feed the a' subtract and the b' add-multiply.
module tiger_round_ctrl #(
  parameter int DLY = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [63:0] i_a,
  input  logic [63:0] i_b,
  input  logic [63:0] i_c,
  input  logic [63:0] i_x,
  input  logic [1:0]  i_mul,
  output logic [7:0]  o_sbox_addr_a,
  output logic [7:0]  o_sbox_addr_b,
  output logic [7:0]  o_sbox_addr_c,
  output logic [7:0]  o_sbox_addr_d,
  input  logic [63:0] i_sbox_data_a,
  input  logic [63:0] i_sbox_data_b,
  input  logic [63:0] i_sbox_data_c,
  input  logic [63:0] i_sbox_data_d,
  output logic [63:0] o_a,
  output logic [63:0] o_b,
  output logic [63:0] o_c,
  output logic        o_busy,
  output logic        o_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LK0  = 2'd1,
    LK1  = 2'd2,
    CALC = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [63:0] a_p0;
  logic [63:0] b_p0;
  logic [63:0] c_p0;
  logic [1:0]  mul_p0;
  logic [63:0] even_p1;
  logic [63:0] odd_sum;

  // DLY only shapes register timing in behavioural models; the datapath ignores it.
  if (DLY < 0) begin : g_dly_invalid
  end

  function automatic logic [7:0] byte_of(input logic [63:0] v, input int k);
    return v[8*k +: 8];
  endfunction

  // Shift-add multiply by 5, 7 or 9, truncated to 64 bits.
  function automatic logic [63:0] mul_small(input logic [63:0] s, input logic [1:0] sel);
    case (sel)
      2'd0:    return (s << 2) + s;
      2'd1:    return (s << 3) - s;
      default: return (s << 3) + s;
    endcase
  endfunction

  assign odd_sum = i_sbox_data_d ^ i_sbox_data_c ^ i_sbox_data_b ^ i_sbox_data_a;
  assign o_busy  = (state != IDLE);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      a_p0    <= '0;
      b_p0    <= '0;
      c_p0    <= '0;
      mul_p0  <= '0;
      even_p1 <= '0;
      o_a     <= '0;
      o_b     <= '0;
      o_c     <= '0;
      o_done  <= 1'b0;
    end else begin
      state  <= state_nxt;
      o_done <= 1'b0;
      case (state)
        // p0: capture operands with the whitened c'
        IDLE: begin
          if (i_start) begin
            c_p0   <= i_c ^ i_x;
            a_p0   <= i_a;
            b_p0   <= i_b;
            mul_p0 <= i_mul;
          end
        end
        // p1: ROMs now present the even-byte lookups
        LK1: even_p1 <= i_sbox_data_a ^ i_sbox_data_b ^ i_sbox_data_c ^ i_sbox_data_d;
        // p2: ROMs now present the odd-byte lookups
        CALC: begin
          o_a    <= a_p0 - even_p1;
          o_b    <= mul_small(b_p0 + odd_sum, mul_p0);
          o_c    <= c_p0;
          o_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt     = state;
    o_sbox_addr_a = 8'd0;
    o_sbox_addr_b = 8'd0;
    o_sbox_addr_c = 8'd0;
    o_sbox_addr_d = 8'd0;
    case (state)
      IDLE: if (i_start) state_nxt = LK0;
      LK0: begin
        o_sbox_addr_a = byte_of(c_p0, 0);
        o_sbox_addr_b = byte_of(c_p0, 2);
        o_sbox_addr_c = byte_of(c_p0, 4);
        o_sbox_addr_d = byte_of(c_p0, 6);
        state_nxt     = LK1;
      end
      LK1: begin
        o_sbox_addr_d = byte_of(c_p0, 1);
        o_sbox_addr_c = byte_of(c_p0, 3);
        o_sbox_addr_b = byte_of(c_p0, 5);
        o_sbox_addr_a = byte_of(c_p0, 7);
        state_nxt     = CALC;
      end
      CALC: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule
